// File: rtl/messbauer_discriminator_pkg.sv
// Shared definitions for the differential discriminator receiver and the spectrum writer.
// Holds the impulse-classifier state encoding and the default counter/channel widths.
package messbauer_discriminator_pkg;

    localparam int CNT_WIDTH_DEFAULT  = 16;
    localparam int CHAN_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_ARM        = 2'd0,
        ST_IDLE       = 2'd1,
        ST_LOWER_HIGH = 2'd2,
        ST_ABORT      = 2'd3
    } disc_state_e;

endpackage

// File: rtl/messbauer_signal_synchronizer.sv
// Two-flop synchroniser for one asynchronous discriminator line.
// Both stages clear to 0 on the synchronous active-low reset.
module messbauer_signal_synchronizer (
    input  logic aclk,
    input  logic areset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/messbauer_diff_discriminator_receiver.sv
// Classifies lower/upper discriminator impulses into accepted/rejected counts per channel
// and hands each closed channel's totals to the spectrum accumulator over valid/ready.
module messbauer_diff_discriminator_receiver
    import messbauer_discriminator_pkg::*;
#(
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int MIN_LOWER_WIDTH = 2,
    parameter int MAX_LOWER_WIDTH = 64,
    parameter int CHAN_WIDTH      = CHAN_WIDTH_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  lower_threshold,
    input  logic                  upper_threshold,
    input  logic                  channel,
    input  logic                  result_ready,
    output logic                  result_valid,
    output logic [CNT_WIDTH-1:0]  accepted_count,
    output logic [CNT_WIDTH-1:0]  rejected_count,
    output logic [CHAN_WIDTH-1:0] channel_index,
    output logic                  overflow,
    output logic                  protocol_error
);

    localparam int WID_W = $clog2(MAX_LOWER_WIDTH + 1);
    localparam logic [WID_W-1:0] MIN_W = WID_W'(MIN_LOWER_WIDTH);
    localparam logic [WID_W-1:0] MAX_W = WID_W'(MAX_LOWER_WIDTH);
    localparam logic [1:0]       ARM_PRIMED = 2'd2;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                     input logic inc);
        if (inc && (val != {CNT_WIDTH{1'b1}})) begin
            return val + CNT_WIDTH'(1);
        end
        return val;
    endfunction

    logic lower_s, upper_s, chan_s;

    messbauer_signal_synchronizer u_sync_lower (
        .aclk     (aclk),
        .areset_n (areset_n),
        .async_in (lower_threshold),
        .sync_out (lower_s)
    );

    messbauer_signal_synchronizer u_sync_upper (
        .aclk     (aclk),
        .areset_n (areset_n),
        .async_in (upper_threshold),
        .sync_out (upper_s)
    );

    messbauer_signal_synchronizer u_sync_chan (
        .aclk     (aclk),
        .areset_n (areset_n),
        .async_in (channel),
        .sync_out (chan_s)
    );

    disc_state_e           state_q, state_d;
    logic                  lower_prev_q, lower_prev_d;
    logic                  chan_prev_q, chan_prev_d;
    logic [1:0]            arm_cnt_q, arm_cnt_d;
    logic [WID_W-1:0]      width_q, width_d;
    logic                  upper_seen_q, upper_seen_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  rej_q, rej_d;
    logic [CNT_WIDTH-1:0]  out_acc_q, out_acc_d;
    logic [CNT_WIDTH-1:0]  out_rej_q, out_rej_d;
    logic [CHAN_WIDTH-1:0] out_idx_q, out_idx_d;
    logic [CHAN_WIDTH-1:0] run_idx_q, run_idx_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;

    logic                  lower_rise, chan_rise;
    logic                  count_acc, count_rej;
    logic [CNT_WIDTH-1:0]  acc_inc, rej_inc;

    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        width_d      = width_q;
        upper_seen_d = upper_seen_q;
        acc_d        = acc_q;
        rej_d        = rej_q;
        out_acc_d    = out_acc_q;
        out_rej_d    = out_rej_q;
        out_idx_d    = out_idx_q;
        run_idx_d    = run_idx_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
        perr_d       = perr_q;
        count_acc    = 1'b0;
        count_rej    = 1'b0;
        lower_prev_d = lower_s;
        chan_prev_d  = chan_s;
        lower_rise   = lower_s & ~lower_prev_q;
        chan_rise    = chan_s & ~chan_prev_q;

        case (state_q)
            // Wait for the synchroniser to fill, so a pulse already high at reset
            // release is seen as a level to wait out rather than as a fresh rise.
            ST_ARM: begin
                if (arm_cnt_q != ARM_PRIMED) begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end else if (!lower_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (lower_rise) begin
                    state_d      = ST_LOWER_HIGH;
                    width_d      = WID_W'(1);
                    upper_seen_d = upper_s;
                end else if (upper_s && !lower_s) begin
                    perr_d = 1'b1;
                end
            end
            ST_LOWER_HIGH: begin
                if (!lower_s) begin
                    state_d = ST_IDLE;
                    if (width_q >= MIN_W) begin
                        count_rej = upper_seen_q;
                        count_acc = ~upper_seen_q;
                    end
                end else if (width_q == MAX_W) begin
                    state_d = ST_ABORT;
                    perr_d  = 1'b1;
                end else begin
                    width_d      = width_q + WID_W'(1);
                    upper_seen_d = upper_seen_q | upper_s;
                end
            end
            ST_ABORT: begin
                if (!lower_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ARM;
        endcase

        acc_inc = sat_inc(acc_q, count_acc);
        rej_inc = sat_inc(rej_q, count_rej);

        // An impulse classified in the closing cycle belongs to the closing channel.
        if (chan_rise) begin
            out_acc_d = acc_inc;
            out_rej_d = rej_inc;
            out_idx_d = run_idx_q;
            run_idx_d = run_idx_q + CHAN_WIDTH'(1);
            acc_d     = '0;
            rej_d     = '0;
            valid_d   = 1'b1;
            if (valid_q && !result_ready) begin
                ovf_d = 1'b1;
            end
        end else begin
            acc_d = acc_inc;
            rej_d = rej_inc;
            if (valid_q && result_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q      <= ST_ARM;
            lower_prev_q <= 1'b0;
            chan_prev_q  <= 1'b0;
            arm_cnt_q    <= 2'd0;
            width_q      <= '0;
            upper_seen_q <= 1'b0;
            acc_q        <= '0;
            rej_q        <= '0;
            out_acc_q    <= '0;
            out_rej_q    <= '0;
            out_idx_q    <= '0;
            run_idx_q    <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lower_prev_q <= lower_prev_d;
            chan_prev_q  <= chan_prev_d;
            arm_cnt_q    <= arm_cnt_d;
            width_q      <= width_d;
            upper_seen_q <= upper_seen_d;
            acc_q        <= acc_d;
            rej_q        <= rej_d;
            out_acc_q    <= out_acc_d;
            out_rej_q    <= out_rej_d;
            out_idx_q    <= out_idx_d;
            run_idx_q    <= run_idx_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            perr_q       <= perr_d;
        end
    end

    assign result_valid   = valid_q;
    assign accepted_count = out_acc_q;
    assign rejected_count = out_rej_q;
    assign channel_index  = out_idx_q;
    assign overflow       = ovf_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_messbauer_diff_discriminator_receiver.sv
// Directed and randomized bench for the discriminator receiver with an impulse-level model.
// Counters are narrowed to 6 bits so saturation is reachable in a short run.
module tb_messbauer_diff_discriminator_receiver;

    localparam int CNT_W  = 6;
    localparam int CHAN_W = 8;
    localparam int MIN_W  = 2;
    localparam int MAX_W  = 64;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int NCHAN  = 1 << CHAN_W;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic              lower_threshold, upper_threshold, channel, result_ready;
    logic              result_valid, overflow, protocol_error;
    logic [CNT_W-1:0]  accepted_count, rejected_count;
    logic [CHAN_W-1:0] channel_index;

    int checks = 0;
    int errors = 0;
    int acc_m, rej_m, idx_m;
    bit ovf_m, perr_m;

    always #5 aclk = ~aclk;

    messbauer_diff_discriminator_receiver #(
        .CNT_WIDTH       (CNT_W),
        .MIN_LOWER_WIDTH (MIN_W),
        .MAX_LOWER_WIDTH (MAX_W),
        .CHAN_WIDTH      (CHAN_W)
    ) dut (
        .aclk            (aclk),
        .areset_n        (areset_n),
        .lower_threshold (lower_threshold),
        .upper_threshold (upper_threshold),
        .channel         (channel),
        .result_ready    (result_ready),
        .result_valid    (result_valid),
        .accepted_count  (accepted_count),
        .rejected_count  (rejected_count),
        .channel_index   (channel_index),
        .overflow        (overflow),
        .protocol_error  (protocol_error)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_clear();
        acc_m = 0; rej_m = 0; idx_m = 0; ovf_m = 0; perr_m = 0;
    endtask

    task automatic do_reset(input string tag);
        areset_n = 0; lower_threshold = 0; upper_threshold = 0;
        channel = 0; result_ready = 0;
        tick(3);
        chk({tag, ":valid"}, result_valid, 0);
        chk({tag, ":acc"}, accepted_count, 0);
        chk({tag, ":rej"}, rejected_count, 0);
        chk({tag, ":idx"}, channel_index, 0);
        chk({tag, ":ovf"}, overflow, 0);
        chk({tag, ":perr"}, protocol_error, 0);
        areset_n = 1;
        tick(5);
        model_clear();
    endtask

    // One lower pulse of w cycles; with up, a 1-cycle upper pulse on its second cycle.
    task automatic pulse(input int w, input bit up);
        for (int i = 0; i < w; i++) begin
            lower_threshold = 1;
            upper_threshold = up && (i == 1);
            tick(1);
        end
        lower_threshold = 0;
        upper_threshold = 0;
        tick(3);
        if (w > MAX_W) perr_m = 1;
        else if (w >= MIN_W) begin
            if (up) rej_m = sat(rej_m);
            else    acc_m = sat(acc_m);
        end
    endtask

    task automatic close_check(input string tag, input bit rdy);
        bit pre;
        int ea, er, ei;
        pre = result_valid;
        result_ready = rdy;
        lower_threshold = 0;
        upper_threshold = 0;
        channel = 1;
        tick(2);
        if (!pre) chk({tag, ":latency"}, result_valid, 0);
        tick(1);
        if (pre && !rdy) ovf_m = 1;
        ea = acc_m; er = rej_m; ei = idx_m;
        chk({tag, ":valid"}, result_valid, 1);
        chk({tag, ":acc"}, accepted_count, ea);
        chk({tag, ":rej"}, rejected_count, er);
        chk({tag, ":idx"}, channel_index, ei);
        chk({tag, ":ovf"}, overflow, ovf_m);
        chk({tag, ":perr"}, protocol_error, perr_m);
        acc_m = 0; rej_m = 0; idx_m = (idx_m + 1) % NCHAN;
        tick(1);
        if (rdy) begin
            chk({tag, ":one_cycle"}, result_valid, 0);
        end else begin
            chk({tag, ":hold_valid"}, result_valid, 1);
            chk({tag, ":hold_acc"}, accepted_count, ea);
            chk({tag, ":hold_idx"}, channel_index, ei);
            result_ready = 1;
            tick(1);
            chk({tag, ":drop"}, result_valid, 0);
        end
        result_ready = 0;
        channel = 0;
        tick(2);
    endtask

    task automatic close_nocheck();
        channel = 1;
        tick(4);
        channel = 0;
        tick(2);
        acc_m = 0; rej_m = 0; idx_m = (idx_m + 1) % NCHAN;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("rst0");

        for (int i = 0; i < 5; i++) pulse(3, 0);
        for (int i = 0; i < 12; i++) pulse(3, 1);
        close_check("basic", 1);

        pulse(1, 0);
        pulse(3, 0);
        close_check("glitch", 1);

        chk("perr_pre", protocol_error, 0);
        upper_threshold = 1;
        tick(1);
        upper_threshold = 0;
        tick(4);
        perr_m = 1;
        chk("perr_upper", protocol_error, perr_m);
        close_check("upper_only", 1);

        do_reset("rst1");
        pulse(70, 0);
        chk("perr_long", protocol_error, perr_m);
        close_check("long", 1);

        do_reset("rst2");
        pulse(3, 0);
        pulse(3, 0);
        close_nocheck();
        chk("ovf_first_valid", result_valid, 1);
        chk("ovf_first_flag", overflow, 0);
        pulse(3, 1);
        close_check("overflow", 0);

        lower_threshold = 1;
        tick(3);
        acc_m = sat(acc_m);
        close_check("same_edge", 1);
        close_check("after_same", 1);

        do_reset("rst3");
        for (int c = 0; c < 15; c++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int p = 0; p < n; p++) begin
                int w;
                bit up;
                w  = $urandom_range(1, 6);
                up = (w >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                pulse(w, up);
            end
            close_check("rand", 1'($urandom_range(0, 1)));
        end

        do_reset("rst4");
        for (int i = 0; i < 70; i++) pulse(2, 0);
        pulse(2, 1);
        close_check("saturate", 1);

        do_reset("rst5");
        for (int i = 0; i < 257; i++) close_check("wrap", 1);

        pulse(3, 0);
        channel = 1;
        tick(4);
        chk("midrst_pending", result_valid, 1);
        lower_threshold = 1;
        areset_n = 0;
        tick(1);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_acc", accepted_count, 0);
        chk("midrst_idx", channel_index, 0);
        channel = 0;
        lower_threshold = 0;
        tick(2);
        areset_n = 1;
        tick(5);
        model_clear();
        close_check("post_rst", 1);

        lower_threshold = 1;
        areset_n = 0;
        tick(3);
        areset_n = 1;
        tick(6);
        lower_threshold = 0;
        tick(4);
        model_clear();
        close_check("arm_high", 1);
        pulse(3, 0);
        close_check("arm_next", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
